fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the MIPS pipeline.
- Sits directly upstream of the control unit and drives its 6-bit opcode input from the registered instruction.
- Consumes the jump / jump-register / branch decisions coming back from decode and execute.
- Owns the PC, next-PC selection, the request/acknowledge handshake to instruction memory, and the stall/flush behaviour of the IF/ID register.

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, stall hold buffer and redirect handling.
// Optional macro FETCH_PERF_CNT_EN adds fetched/squashed performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] reg_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_buf;
    logic [31:0] r_buf_pc4;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc4;
    logic        r_if_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_target_al;
    logic [31:0] w_pc4;

    assign w_redirect  = jump_reg | branch_taken | jump;
    assign w_target    = jump_reg     ? reg_target :
                         branch_taken ? branch_target :
                                        {r_if_pc4[31:28], r_if_instr[25:0], 2'b00};
    assign w_target_al = w_target & 32'hFFFF_FFFC;
    assign w_pc4       = r_pc + 32'd4;

    // Request path depends only on state and registers, never on imem_ack.
    assign imem_req    = rst_n && (r_state != S_HOLD);
    assign imem_addr   = (r_state == S_DROP) ? r_req_addr : r_pc;

    assign if_id_instr = r_if_instr;
    assign if_id_pc4   = r_if_pc4;
    assign if_id_valid = r_if_valid;
    assign opcode      = r_if_valid ? r_if_instr[31:26] : 6'b000000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC & 32'hFFFF_FFFC;
            r_req_addr <= RESET_PC & 32'hFFFF_FFFC;
            r_buf      <= 32'd0;
            r_buf_pc4  <= 32'd0;
            r_if_instr <= 32'd0;
            r_if_pc4   <= 32'd0;
            r_if_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_redirect) begin
                        r_pc       <= w_target_al;
                        r_if_valid <= 1'b0;
                        if (!imem_ack) begin
                            // Request already issued: keep its address until the ack drains it.
                            r_req_addr <= r_pc;
                            r_state    <= S_DROP;
                        end
                    end else if (imem_ack) begin
                        r_pc <= w_pc4;
                        if (stall || flush) begin
                            r_buf     <= imem_rdata;
                            r_buf_pc4 <= w_pc4;
                            r_state   <= S_HOLD;
                            if (flush) r_if_valid <= 1'b0;
                        end else begin
                            r_if_instr <= imem_rdata;
                            r_if_pc4   <= w_pc4;
                            r_if_valid <= 1'b1;
                        end
                    end else if (flush || !stall) begin
                        r_if_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_pc       <= w_target_al;
                        r_if_valid <= 1'b0;
                        r_state    <= S_FETCH;
                    end else if (flush) begin
                        r_if_valid <= 1'b0;
                    end else if (!stall) begin
                        r_if_instr <= r_buf;
                        r_if_pc4   <= r_buf_pc4;
                        r_if_valid <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (w_redirect) r_pc <= w_target_al;
                    if (flush)      r_if_valid <= 1'b0;
                    if (imem_ack)   r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_ev_fetch;
    logic        w_ev_squash;
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_squashed;

    assign w_ev_fetch  = ((r_state == S_FETCH) && imem_ack && !w_redirect && !stall && !flush) ||
                         ((r_state == S_HOLD) && !w_redirect && !flush && !stall);
    assign w_ev_squash = ((r_state == S_FETCH) && imem_ack && w_redirect) ||
                         ((r_state == S_HOLD) && w_redirect) ||
                         ((r_state == S_DROP) && imem_ack);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetched  <= 32'd0;
            r_perf_squashed <= 32'd0;
        end else begin
            if (w_ev_fetch)  r_perf_fetched  <= r_perf_fetched + 32'd1;
            if (w_ev_squash) r_perf_squashed <= r_perf_squashed + 32'd1;
        end
    end

    assign perf_fetched  = r_perf_fetched;
    assign perf_squashed = r_perf_squashed;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized stall/latency/redirect run.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n, stall, flush, jump, jump_reg, branch_taken;
    logic [31:0] branch_target, reg_target;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_squashed;
`endif

    int errors = 0;
    int checks = 0;

    // Instruction memory responder: automatic (word = 0x8C000000 + addr, programmable latency) or manual.
    logic        auto_mode = 1'b1;
    logic        lat_rand  = 1'b0;
    int          lat_fix   = 0;
    int          lat_cur   = 0;
    int          wcnt      = 0;
    logic        man_ack   = 1'b0;
    logic [31:0] man_data  = 32'd0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .jump(jump), .jump_reg(jump_reg), .branch_taken(branch_taken),
        .branch_target(branch_target), .reg_target(reg_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .opcode(opcode)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
    );

    always @* begin
        if (auto_mode) begin
            imem_ack   = imem_req && (wcnt >= lat_cur);
            imem_rdata = imem_ack ? (32'h8C00_0000 + imem_addr) : 32'd0;
        end else begin
            imem_ack   = man_ack;
            imem_rdata = man_data;
        end
    end

    always @(posedge clk) begin
        if (!rst_n || !imem_req || imem_ack) begin
            wcnt    <= 0;
            lat_cur <= lat_rand ? int'($urandom_range(2, 0)) : lat_fix;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic am, input int lat);
        auto_mode = am; lat_fix = lat; lat_rand = 1'b0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; jump = 1'b0; jump_reg = 1'b0;
        branch_taken = 1'b0; branch_target = 32'd0; reg_target = 32'd0;
        man_ack = 1'b0; man_data = 32'd0;
        step; step;
    endtask

    task automatic test_reset;
        do_reset(1'b1, 0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        checks++; if (if_id_instr !== 32'd0 || if_id_pc4 !== 32'd0) begin errors++; $display("FAIL reset_ifid: got %h/%h want 0/0", if_id_instr, if_id_pc4); end
        checks++; if (opcode !== 6'd0) begin errors++; $display("FAIL reset_opcode: got %b want 0", opcode); end
    endtask

    task automatic test_stream;
        logic [31:0] a;
        do_reset(1'b1, 0);
        rst_n = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL stream_first_req: got %b/%h want 1/00000100", imem_req, imem_addr); end
        step;
        checks++; if (opcode !== 6'b100011) begin errors++; $display("FAIL stream_opcode: got %b want 100011", opcode); end
        a = 32'h100;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (if_id_valid !== 1'b1 || if_id_instr !== 32'h8C00_0000 + a || if_id_pc4 !== a + 32'd4) begin
                errors++; $display("FAIL stream_%0d: got %b/%h/%h want 1/%h/%h", i, if_id_valid, if_id_instr, if_id_pc4, 32'h8C00_0000 + a, a + 32'd4);
            end
            a = a + 32'd4;
            step;
        end
    endtask

    task automatic test_wait;
        do_reset(1'b1, 3);
        rst_n = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin
                errors++; $display("FAIL wait_cyc%0d: got req=%b addr=%h v=%b want 1/00000100/0", i, imem_req, imem_addr, if_id_valid);
            end
            step;
        end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL wait_ack_addr: got %h want 00000100", imem_addr); end
        step;
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h8C00_0100 || if_id_pc4 !== 32'h104) begin
            errors++; $display("FAIL wait_data: got %b/%h/%h want 1/8c000100/00000104", if_id_valid, if_id_instr, if_id_pc4);
        end
    endtask

    task automatic test_stall;
        do_reset(1'b1, 0);
        rst_n = 1'b1; step;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step;
            checks++; if (if_id_instr !== 32'h8C00_0100 || if_id_pc4 !== 32'h104 || if_id_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: got %h/%h/%b req=%b want 8c000100/00000104/1 req=0", i, if_id_instr, if_id_pc4, if_id_valid, imem_req);
            end
        end
        stall = 1'b0; step;
        checks++; if (if_id_instr !== 32'h8C00_0104 || if_id_pc4 !== 32'h108 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL stall_release: got %h/%h/%b want 8c000104/00000108/1", if_id_instr, if_id_pc4, if_id_valid);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin errors++; $display("FAIL stall_next_addr: got %b/%h want 1/00000108", imem_req, imem_addr); end
        step;
        checks++; if (if_id_instr !== 32'h8C00_0108 || if_id_pc4 !== 32'h10C) begin
            errors++; $display("FAIL stall_after: got %h/%h want 8c000108/0000010c", if_id_instr, if_id_pc4);
        end
    endtask

    task automatic test_jump;
        do_reset(1'b0, 0);
        rst_n = 1'b1;
        jump_reg = 1'b1; reg_target = 32'h0040_0004; man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
        step;
        checks++; if (imem_addr !== 32'h0040_0004 || if_id_valid !== 1'b0) begin errors++; $display("FAIL jr_setup: got %h/%b want 00400004/0", imem_addr, if_id_valid); end
        jump_reg = 1'b0; man_data = 32'h0800_0040;
        step;
        checks++; if (if_id_instr !== 32'h0800_0040 || if_id_pc4 !== 32'h0040_0008 || opcode !== 6'b000010) begin
            errors++; $display("FAIL jump_ifid: got %h/%h/%b want 08000040/00400008/000010", if_id_instr, if_id_pc4, opcode);
        end
        jump = 1'b1; man_data = 32'h1111_1111;
        step;
        checks++; if (imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin errors++; $display("FAIL jump_target: got %h/%b want 00000100/0", imem_addr, if_id_valid); end
        jump = 1'b0; man_data = 32'h0800_0040;
        step;
        checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h104) begin errors++; $display("FAIL jump_resume: got %b/%h want 1/00000104", if_id_valid, if_id_pc4); end
        jump = 1'b1; jump_reg = 1'b1; reg_target = 32'h200;
        step;
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL prio_jr_over_j: got %h want 00000200", imem_addr); end
        jump = 1'b0; jump_reg = 1'b0;
        step;
        jump = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
        step;
        checks++; if (imem_addr !== 32'h300) begin errors++; $display("FAIL prio_br_over_j: got %h want 00000300", imem_addr); end
        jump = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_drop;
        do_reset(1'b0, 0);
        rst_n = 1'b1; man_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h400;
        step;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL drop_hold_addr: got %b/%h/%b want 1/00000100/0", imem_req, imem_addr, if_id_valid);
        end
        branch_taken = 1'b0; man_ack = 1'b1; man_data = 32'hBAD0_BAD0;
        step;
        checks++; if (imem_addr !== 32'h400 || if_id_valid !== 1'b0) begin errors++; $display("FAIL drop_discard: got %h/%b want 00000400/0", imem_addr, if_id_valid); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_squashed !== 32'd1) begin errors++; $display("FAIL perf_squashed1: got %0d want 1", perf_squashed); end
`endif
        man_data = 32'h8C00_0400;
        step;
        checks++; if (if_id_instr !== 32'h8C00_0400 || if_id_pc4 !== 32'h404 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL drop_target_fetch: got %h/%h/%b want 8c000400/00000404/1", if_id_instr, if_id_pc4, if_id_valid);
        end
        man_ack = 1'b0; jump_reg = 1'b1; reg_target = 32'h500;
        step;
        reg_target = 32'h600;
        step;
        checks++; if (imem_addr !== 32'h404) begin errors++; $display("FAIL drop_redirect_again: got %h want 00000404", imem_addr); end
        jump_reg = 1'b0; man_ack = 1'b1;
        step;
        checks++; if (imem_addr !== 32'h600) begin errors++; $display("FAIL drop_last_target: got %h want 00000600", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_squashed !== 32'd2 || perf_fetched !== 32'd1) begin
            errors++; $display("FAIL perf_counts: got sq=%0d f=%0d want 2/1", perf_squashed, perf_fetched);
        end
`endif
    endtask

    task automatic test_flush;
        do_reset(1'b1, 0);
        rst_n = 1'b1; step;
        flush = 1'b1; step;
        checks++; if (if_id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL flush_kill: got v=%b req=%b want 0/0", if_id_valid, imem_req); end
        flush = 1'b0; step;
        checks++; if (if_id_instr !== 32'h8C00_0104 || if_id_pc4 !== 32'h108 || if_id_valid !== 1'b1 || imem_addr !== 32'h108) begin
            errors++; $display("FAIL flush_buffered: got %h/%h/%b addr=%h want 8c000104/00000108/1 addr=00000108", if_id_instr, if_id_pc4, if_id_valid, imem_addr);
        end
    endtask

    task automatic test_wrap;
        do_reset(1'b0, 0);
        rst_n = 1'b1; jump_reg = 1'b1; reg_target = 32'hFFFF_FFFE; man_ack = 1'b1; man_data = 32'h0;
        step;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL align: got %h want fffffffc", imem_addr); end
        jump_reg = 1'b0; man_data = 32'h1234_5678;
        step;
        checks++; if (if_id_pc4 !== 32'd0 || imem_addr !== 32'd0 || if_id_instr !== 32'h1234_5678) begin
            errors++; $display("FAIL wrap: got pc4=%h addr=%h instr=%h want 0/0/12345678", if_id_pc4, imem_addr, if_id_instr);
        end
    endtask

    task automatic test_reset_mid;
        do_reset(1'b1, 0);
        rst_n = 1'b1; step;
        stall = 1'b1; step;
        rst_n = 1'b0; step;
        checks++; if (if_id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rst_hold: got v=%b req=%b want 0/0", if_id_valid, imem_req); end
        rst_n = 1'b1; stall = 1'b0; #1;
        checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL rst_hold_pc: got %h/%b want 00000100/1", imem_addr, imem_req); end
        step;
        checks++; if (if_id_instr !== 32'h8C00_0100 || if_id_pc4 !== 32'h104) begin
            errors++; $display("FAIL rst_hold_refetch: got %h/%h want 8c000100/00000104", if_id_instr, if_id_pc4);
        end
        do_reset(1'b0, 0);
        rst_n = 1'b1; branch_taken = 1'b1; branch_target = 32'h400;
        step;
        branch_taken = 1'b0; rst_n = 1'b0; man_ack = 1'b1; man_data = 32'hBAD0_0BAD;
        step;
        checks++; if (if_id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rst_drop: got v=%b req=%b want 0/0", if_id_valid, imem_req); end
        rst_n = 1'b1; man_ack = 1'b0; #1;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rst_drop_pc: got %h want 00000100", imem_addr); end
        man_ack = 1'b1; man_data = 32'h8C00_0100;
        step;
        checks++; if (if_id_instr !== 32'h8C00_0100 || if_id_pc4 !== 32'h104 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL rst_drop_refetch: got %h/%h/%b want 8c000100/00000104/1", if_id_instr, if_id_pc4, if_id_valid);
        end
    endtask

    // Reference: decode consumes IF/ID whenever valid and not stalled; consumed words must follow
    // program order (sequential, restarting at each redirect target) with nothing lost or repeated.
    task automatic test_random;
        logic [31:0] exp_pc, s_instr, s_pc4, p_addr;
        logic        s_valid, s_stall, p_req, p_ack;
        int          consumed;
        do_reset(1'b1, 0);
        lat_rand = 1'b1;
        rst_n = 1'b1;
        exp_pc = 32'h100; consumed = 0; p_req = 1'b0; p_ack = 1'b0; p_addr = 32'd0;
        for (int c = 0; c < 600; c++) begin
            stall    = ($urandom % 10) < 3;
            jump_reg = !stall && (($urandom % 20) == 0);
            reg_target = 32'($urandom_range(32'h3FF, 32'h40)) << 2;
            #1;
            if (p_req && !p_ack && imem_req) begin
                checks++; if (imem_addr !== p_addr) begin errors++; $display("FAIL rnd_addr_stable c%0d: got %h want %h", c, imem_addr, p_addr); end
            end
            if (if_id_valid && !stall) begin
                checks++;
                if (if_id_instr !== 32'h8C00_0000 + exp_pc || if_id_pc4 !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL rnd_order c%0d: got %h/%h want %h/%h", c, if_id_instr, if_id_pc4, 32'h8C00_0000 + exp_pc, exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (jump_reg) exp_pc = reg_target;
            s_instr = if_id_instr; s_pc4 = if_id_pc4; s_valid = if_id_valid; s_stall = stall;
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            @(posedge clk); #1;
            if (s_stall) begin
                checks++;
                if (if_id_instr !== s_instr || if_id_pc4 !== s_pc4 || if_id_valid !== s_valid) begin
                    errors++; $display("FAIL rnd_stall_hold c%0d: got %h/%h/%b want %h/%h/%b", c, if_id_instr, if_id_pc4, if_id_valid, s_instr, s_pc4, s_valid);
                end
            end
        end
        jump_reg = 1'b0; stall = 1'b0; lat_rand = 1'b0;
        checks++; if (consumed < 100) begin errors++; $display("FAIL rnd_progress: got %0d want >=100", consumed); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_wait;
        test_stall;
        test_jump;
        test_drop;
        test_flush;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
